// File: rtl/conv_display_scan_ctrl_if.sv
// Value/mode handshake plus the shared segment/anode pins of the two-digit display.
interface conv_display_scan_ctrl_if;
    logic       val_valid;
    logic       val_ready;
    logic [3:0] val;
    logic [1:0] mode;
    logic [6:0] seg_n;
    logic [1:0] an_n;

    modport master (output val_valid, val, mode, input  val_ready, seg_n, an_n);
    modport slave  (input  val_valid, val, mode, output val_ready, seg_n, an_n);
endinterface

// File: rtl/conv_display_scan_ctrl.sv
// Two-digit 7-segment scan controller; new values commit only at frame boundaries. Optional macro: LZ_BLANK_EN.
// Latency: value shows from the first S_DIG0 after the next S_BLANK1; pins lag the scan state by one registered cycle.
// Backpressure: val_ready holds low from an accepted transfer until the next frame-boundary commit.
module conv_display_scan_ctrl #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input logic                      clk,
    input logic                      rst,
    conv_display_scan_ctrl_if.slave  bus
);
    localparam int MAXN = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXN);
    localparam logic [CW-1:0] DIG_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [6:0]    DASH     = 7'b0000001;

    typedef enum logic [1:0] {S_DIG0, S_BLANK0, S_DIG1, S_BLANK1} state_t;
    typedef struct packed {
        logic [1:0] mode;
        logic [3:0] val;
    } disp_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    disp_t           shown_q, pend_q;
    logic            ready_q;
    logic [6:0]      seg_q, seg_d;
    logic [1:0]      an_q, an_d;
    logic            last, commit, take, dash;
    logic [3:0]      tens, ones;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 7'b1111110;  4'h1: glyph = 7'b0110000;
            4'h2: glyph = 7'b1101101;  4'h3: glyph = 7'b1111001;
            4'h4: glyph = 7'b0110011;  4'h5: glyph = 7'b1011011;
            4'h6: glyph = 7'b1011111;  4'h7: glyph = 7'b1110000;
            4'h8: glyph = 7'b1111111;  4'h9: glyph = 7'b1111011;
            4'hA: glyph = 7'b1110111;  4'hB: glyph = 7'b0011111;
            4'hC: glyph = 7'b1001110;  4'hD: glyph = 7'b0111101;
            4'hE: glyph = 7'b1001111;  default: glyph = 7'b1000111;
        endcase
    endfunction

    assign take   = bus.val_valid && ready_q;
    assign commit = (state_q == S_BLANK1) && last;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        last    = (state_q == S_DIG0 || state_q == S_DIG1) ? (cnt_q == DIG_LAST)
                                                           : (cnt_q == BLK_LAST);
        if (last) begin
            cnt_d = '0;
            case (state_q)
                S_DIG0:   state_d = S_BLANK0;
                S_BLANK0: state_d = S_DIG1;
                S_DIG1:   state_d = S_BLANK1;
                default:  state_d = S_DIG0;
            endcase
        end
    end

    // Digit split of the committed value; mode 3 renders a dash on both digits.
    always_comb begin
        tens = 4'd0;
        ones = shown_q.val;
        dash = 1'b0;
        case (shown_q.mode)
            2'd0: if (shown_q.val >= 4'd10) begin
                      tens = 4'd1;
                      ones = shown_q.val - 4'd10;
                  end
            2'd1: begin
                      tens = {3'b000, shown_q.val[3]};
                      ones = {1'b0, shown_q.val[2:0]};
                  end
            2'd2: ;
            default: dash = 1'b1;
        endcase
    end

    always_comb begin
        seg_d = 7'h7F;
        an_d  = 2'b11;
        case (state_q)
            S_DIG0: begin
                an_d  = 2'b10;
                seg_d = dash ? ~DASH : ~glyph(ones);
            end
            S_DIG1: begin
                an_d  = 2'b01;
                seg_d = dash ? ~DASH : ~glyph(tens);
`ifdef LZ_BLANK_EN
                if (!dash && tens == 4'd0) seg_d = 7'h7F;
`else
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_BLANK1;
            cnt_q   <= '0;
            shown_q <= '0;
            pend_q  <= '0;
            ready_q <= 1'b1;
            seg_q   <= 7'h7F;
            an_q    <= 2'b11;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            // ready_q low means pend_q holds an uncommitted value.
            if (commit && !ready_q) begin
                shown_q <= pend_q;
                ready_q <= 1'b1;
            end
            if (take) begin
                pend_q  <= '{mode: bus.mode, val: bus.val};
                ready_q <= 1'b0;
            end
        end
    end

    assign bus.val_ready = ready_q;
    assign bus.seg_n     = seg_q;
    assign bus.an_n      = an_q;
endmodule

// File: tb/tb_conv_display_scan_ctrl.sv
// Bench for conv_display_scan_ctrl at REFRESH_DIV=4, BLANK_CYCLES=2: frame-position model plus directed literals.
module tb_conv_display_scan_ctrl;
    localparam int R = 4;
    localparam int B = 2;
    localparam int P = 2 * R + 2 * B;
`ifdef LZ_BLANK_EN
    localparam logic [6:0] TZ = 7'h7F;
`else
    localparam logic [6:0] TZ = 7'h01;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    conv_display_scan_ctrl_if bus ();

    conv_display_scan_ctrl #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1111110;   1: return 7'b0110000;   2: return 7'b1101101;
            3: return 7'b1111001;   4: return 7'b0110011;   5: return 7'b1011011;
            6: return 7'b1011111;   7: return 7'b1110000;   8: return 7'b1111111;
            9: return 7'b1111011;  10: return 7'b1110111;  11: return 7'b0011111;
           12: return 7'b1001110;  13: return 7'b0111101;  14: return 7'b1001111;
           default: return 7'b1000111;
        endcase
    endfunction

    // Model: position within the repeating frame derived from edges since reset release.
    int         k = 0;
    logic       m_ready = 1'b1;
    int         m_sv = 0, m_sm = 0, m_pv = 0, m_pm = 0;

    always @(posedge clk) begin
        logic       take;
        int         p, t, o;
        logic [1:0] e_an;
        logic [6:0] e_seg, s_ones, s_tens;
        take = bus.val_valid && m_ready;
        if (rst) begin
            k = 0; m_ready = 1'b1; m_sv = 0; m_sm = 0;
        end else begin
            k++;
            if (k >= B && (k - B) % P == 0 && !m_ready) begin
                m_sv = m_pv; m_sm = m_pm; m_ready = 1'b1;
            end
            if (take) begin
                m_pv = int'(bus.val); m_pm = int'(bus.mode); m_ready = 1'b0;
            end
        end
        case (m_sm)
            0: begin t = m_sv / 10; o = m_sv % 10; end
            1: begin t = m_sv / 8;  o = m_sv % 8;  end
            default: begin t = 0;   o = m_sv;      end
        endcase
        s_ones = ~glyph(o);
        s_tens = (t == 0) ? TZ : ~glyph(t);
        if (m_sm == 3) begin s_ones = 7'h7E; s_tens = 7'h7E; end
        e_an = 2'b11; e_seg = 7'h7F;
        if (!rst && k > B) begin
            p = (k - B - 1) % P;
            if (p < R) begin e_an = 2'b10; e_seg = s_ones; end
            else if (p >= R + B && p < 2 * R + B) begin e_an = 2'b01; e_seg = s_tens; end
        end
        #1;
        chk("model an_n", 32'(bus.an_n), 32'(e_an));
        chk("model seg_n", 32'(bus.seg_n), 32'(e_seg));
        chk("model val_ready", 32'(bus.val_ready), 32'(m_ready));
    end

    task automatic wait_enter(input logic [1:0] target, input string name);
        int n = 0;
        while (bus.an_n === target && n < 40) begin @(negedge clk); n++; end
        while (bus.an_n !== target && n < 40) begin @(negedge clk); n++; end
        chk({name, " reached"}, 32'(bus.an_n), 32'(target));
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (bus.val_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk({name, " ready returns"}, 32'(bus.val_ready), 32'd1);
    endtask

    task automatic send(input logic [3:0] v, input logic [1:0] m, input string name);
        chk({name, " ready before"}, 32'(bus.val_ready), 32'd1);
        bus.val_valid = 1'b1; bus.val = v; bus.mode = m;
        @(negedge clk);
        bus.val_valid = 1'b0;
        chk({name, " ready drop"}, 32'(bus.val_ready), 32'd0);
    endtask

    task automatic show(input logic [6:0] e_ones, input logic [6:0] e_tens, input string name);
        wait_ready(name);
        wait_enter(2'b10, name);
        chk({name, " ones"}, 32'(bus.seg_n), 32'(e_ones));
        wait_enter(2'b01, name);
        chk({name, " tens"}, 32'(bus.seg_n), 32'(e_tens));
    endtask

    initial begin
        rst = 1'b1; bus.val_valid = 1'b0; bus.val = 4'd0; bus.mode = 2'd0;
        repeat (3) @(negedge clk);
        chk("reset an_n", 32'(bus.an_n), 32'h3);
        chk("reset seg_n", 32'(bus.seg_n), 32'h7F);
        chk("reset ready", 32'(bus.val_ready), 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("blank1 after release", 32'(bus.an_n), 32'h3);
        @(negedge clk);
        chk("first digit an_n", 32'(bus.an_n), 32'h2);
        chk("first digit seg_n", 32'(bus.seg_n), 32'h01);
        repeat (3) @(negedge clk);
        chk("dig0 dwell end", 32'(bus.an_n), 32'h2);
        @(negedge clk);
        chk("blank0", 32'(bus.an_n), 32'h3);
        repeat (2) @(negedge clk);
        chk("dig1 an_n", 32'(bus.an_n), 32'h1);
        chk("dig1 tens zero", 32'(bus.seg_n), 32'(TZ));
        repeat (4) @(negedge clk);
        chk("blank1", 32'(bus.an_n), 32'h3);
        repeat (2) @(negedge clk);
        chk("second frame dig0", 32'(bus.an_n), 32'h2);

        send(4'd13, 2'd0, "dec13");
        show(7'h06, 7'h4F, "dec13");
        send(4'd15, 2'd1, "oct15");
        show(7'h0F, 7'h4F, "oct15");
        send(4'd11, 2'd2, "hex11");
        show(7'h60, TZ, "hex11");
        send(4'd9, 2'd3, "dash9");
        show(7'h7E, 7'h7E, "dash9");

        // Offer during S_DIG1 and hold valid through the stall.
        wait_enter(2'b01, "mid dig1");
        bus.val_valid = 1'b1; bus.val = 4'd5; bus.mode = 2'd0;
        @(negedge clk);
        chk("old tens finishes", 32'(bus.seg_n), 32'h7E);
        chk("held ready low", 32'(bus.val_ready), 32'd0);
        wait_ready("held");
        bus.val_valid = 1'b0;
        wait_enter(2'b10, "dec5");
        chk("dec5 ones", 32'(bus.seg_n), 32'h24);
        wait_enter(2'b01, "dec5");
        chk("dec5 tens", 32'(bus.seg_n), 32'(TZ));

        // Transfer lands on the commit edge itself.
        wait_enter(2'b11, "pre commit");
        bus.val_valid = 1'b1; bus.val = 4'd8; bus.mode = 2'd1;
        @(negedge clk);
        bus.val_valid = 1'b0;
        chk("commit-cycle take", 32'(bus.val_ready), 32'd0);
        wait_enter(2'b10, "deferred");
        chk("deferred keeps old", 32'(bus.seg_n), 32'h24);
        show(7'h01, 7'h4F, "oct8");

        // Reset while a value is pending.
        wait_enter(2'b10, "pre reset");
        send(4'd9, 2'd0, "pend9");
        rst = 1'b1;
        @(negedge clk);
        chk("mid rst an_n", 32'(bus.an_n), 32'h3);
        chk("mid rst seg_n", 32'(bus.seg_n), 32'h7F);
        chk("mid rst ready", 32'(bus.val_ready), 32'd1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post rst an_n", 32'(bus.an_n), 32'h2);
        chk("post rst shown 0", 32'(bus.seg_n), 32'h01);
        wait_enter(2'b01, "post rst");
        chk("post rst tens", 32'(bus.seg_n), 32'(TZ));
        wait_enter(2'b10, "discarded");
        chk("pending discarded", 32'(bus.seg_n), 32'h01);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
